// File: rtl/sprite_line_scheduler.sv
// sprite_line_scheduler: per-scanline sprite evaluator that fills a pending slot table
// and swaps it into the active tile-draw slot table on each line-start pulse.
module sprite_line_scheduler #(
    parameter int SPRITE_NUM = 64,
    parameter int SLOT_NUM   = 8,
    parameter int TILE_H     = 8,
    parameter int LINE_W     = 10,
    localparam int IDX_W     = $clog2(SPRITE_NUM)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      lineStart,
    input  logic [LINE_W-1:0]         nextLineY,
    output logic [IDX_W-1:0]          ramIndex,
    input  logic [31:0]               ramData,
    output logic [SLOT_NUM*IDX_W-1:0] slotIdx,
    output logic [SLOT_NUM-1:0]       slotValid,
    output logic                      lineOverflow,
    output logic                      busy,
    output logic                      evalDone,
    output logic                      evalLate
);
    localparam int CNT_W  = $clog2(SLOT_NUM + 1);
    localparam int SLOT_W = $clog2(SLOT_NUM);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                    r_state;
    logic [LINE_W-1:0]         r_y;
    logic [IDX_W-1:0]          r_cmp_idx;
    logic                      r_cmp_vld;
    logic [SLOT_NUM*IDX_W-1:0] r_pidx;
    logic [SLOT_NUM-1:0]       r_pvld;
    logic                      r_povf;
    logic [CNT_W-1:0]          r_cnt;

    logic [LINE_W:0]  w_y;
    logic [LINE_W:0]  w_pos;
    logic             w_hit;
    logic             w_last;
    logic             w_full;
    logic [SLOT_W-1:0] w_slot;
    logic             w_unused;

    // One extra bit keeps posY + TILE_H from wrapping for bands that start near 255
    assign w_y      = {1'b0, r_y};
    assign w_pos    = (LINE_W + 1)'(ramData[23:16]);
    assign w_hit    = r_cmp_vld && w_y >= w_pos && w_y < w_pos + (LINE_W + 1)'(TILE_H);
    assign w_last   = r_cmp_vld && r_cmp_idx == IDX_W'(SPRITE_NUM - 1);
    assign w_full   = r_cnt == CNT_W'(SLOT_NUM);
    assign w_slot   = r_cnt[SLOT_W-1:0];
    assign w_unused = ^{ramData[31:24], ramData[15:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_y          <= '0;
            r_cmp_idx    <= '0;
            r_cmp_vld    <= 1'b0;
            r_pidx       <= '0;
            r_pvld       <= '0;
            r_povf       <= 1'b0;
            r_cnt        <= '0;
            ramIndex     <= '0;
            slotIdx      <= '0;
            slotValid    <= '0;
            lineOverflow <= 1'b0;
            busy         <= 1'b0;
            evalDone     <= 1'b0;
            evalLate     <= 1'b0;
        end else begin
            evalDone <= 1'b0;
            evalLate <= 1'b0;
            if (lineStart) begin
                slotIdx      <= r_pidx;
                slotValid    <= r_pvld;
                lineOverflow <= r_povf;
                r_pidx       <= '0;
                r_pvld       <= '0;
                r_povf       <= 1'b0;
                r_cnt        <= '0;
                r_y          <= nextLineY;
                ramIndex     <= '0;
                r_cmp_vld    <= 1'b0;
                busy         <= 1'b1;
                evalLate     <= r_state == SCAN;
                evalDone     <= r_state == DONE;
                r_state      <= SCAN;
            end else if (r_state == SCAN) begin
                // Data on ramData belongs to the index issued one cycle earlier
                r_cmp_vld <= 1'b1;
                r_cmp_idx <= ramIndex;
                if (ramIndex != IDX_W'(SPRITE_NUM - 1))
                    ramIndex <= ramIndex + 1'b1;
                if (w_hit && w_full) begin
                    r_povf  <= 1'b1;
                    r_state <= DONE;
                end else begin
                    if (w_hit) begin
                        r_pidx[w_slot*IDX_W +: IDX_W] <= r_cmp_idx;
                        r_pvld[w_slot]                <= 1'b1;
                        r_cnt                         <= r_cnt + 1'b1;
                    end
                    if (w_last)
                        r_state <= DONE;
                end
            end else if (r_state == DONE) begin
                evalDone <= 1'b1;
                busy     <= 1'b0;
                r_state  <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_sprite_line_scheduler.sv
// tb_sprite_line_scheduler: directed table-driven checks of the sprite line scheduler
// against a synchronous-read sprite RAM model.
module tb_sprite_line_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lineStart = 1'b0;
    logic [9:0]  nextLineY = '0;
    logic [5:0]  ramIndex;
    logic [31:0] ramData = '0;
    logic [47:0] slotIdx;
    logic [7:0]  slotValid;
    logic        lineOverflow, busy, evalDone, evalLate;

    logic [31:0] mem [64];
    int checks = 0;
    int errors = 0;

    sprite_line_scheduler dut (
        .clk(clk), .rst(rst), .lineStart(lineStart), .nextLineY(nextLineY),
        .ramIndex(ramIndex), .ramData(ramData), .slotIdx(slotIdx), .slotValid(slotValid),
        .lineOverflow(lineOverflow), .busy(busy), .evalDone(evalDone), .evalLate(evalLate)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ramData <= mem[ramIndex];

    typedef struct {
        int         spr;
        logic [7:0] posy;
        logic [9:0] y;
        logic [7:0] vld;
        logic [5:0] s0;
    } vec_t;

    vec_t vt [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bg();
        for (int i = 0; i < 64; i++) mem[i] = {8'h3C, 8'd240, 10'd0, 6'(i)};
    endtask

    task automatic set_spr(input int k, input logic [7:0] p);
        mem[k] = {8'hA5, p, 16'h1234};
    endtask

    task automatic start_line(input logic [9:0] y);
        lineStart = 1'b1;
        nextLineY = y;
        tick();
        lineStart = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!evalDone && n < 200) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        logic [47:0] exp_idx;
        vt[0] = '{5, 8'd20,  10'd23,  8'h01, 6'd5};
        vt[1] = '{0, 8'd10,  10'd9,   8'h00, 6'd0};
        vt[2] = '{0, 8'd10,  10'd10,  8'h01, 6'd0};
        vt[3] = '{0, 8'd10,  10'd17,  8'h01, 6'd0};
        vt[4] = '{0, 8'd10,  10'd18,  8'h00, 6'd0};
        vt[5] = '{3, 8'd255, 10'd261, 8'h01, 6'd3};
        vt[6] = '{3, 8'd255, 10'd5,   8'h00, 6'd0};
        vt[7] = '{3, 8'd255, 10'd262, 8'h01, 6'd3};
        vt[8] = '{3, 8'd255, 10'd263, 8'h00, 6'd0};
        set_bg();
        #3;
        chk("reset outputs", {slotIdx, slotValid, lineOverflow, busy, evalDone, evalLate, ramIndex}, '0);
        tick();
        rst = 1'b0;
        tick();

        for (int v = 0; v < 9; v++) begin
            set_bg();
            set_spr(vt[v].spr, vt[v].posy);
            start_line(vt[v].y);
            chk($sformatf("vec%0d busy", v), busy, 1'b1);
            wait_done(n);
            chk($sformatf("vec%0d done latency", v), n, 66);
            start_line(10'd0);
            chk($sformatf("vec%0d slotValid", v), slotValid, vt[v].vld);
            chk($sformatf("vec%0d slotIdx", v), slotIdx, {42'd0, vt[v].s0});
            chk($sformatf("vec%0d overflow", v), lineOverflow, 1'b0);
            wait_done(n);
        end

        // Overflow with early stop on index 8
        set_bg();
        for (int i = 0; i < 10; i++) set_spr(i, 8'd50);
        start_line(10'd52);
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        chk("ovf busy drop", n, 11);
        chk("ovf evalDone", evalDone, 1'b1);
        start_line(10'd0);
        for (int s = 0; s < 8; s++) exp_idx[s*6 +: 6] = 6'(s);
        chk("ovf slotIdx", slotIdx, exp_idx);
        chk("ovf slotValid", slotValid, 8'hFF);
        chk("ovf lineOverflow", lineOverflow, 1'b1);
        wait_done(n);

        // Late line: second lineStart 20 cycles into the scan
        set_bg();
        set_spr(2, 8'd100);
        set_spr(40, 8'd100);
        start_line(10'd103);
        repeat (19) tick();
        chk("late busy", busy, 1'b1);
        start_line(10'd103);
        chk("late evalLate", evalLate, 1'b1);
        chk("late evalDone", evalDone, 1'b0);
        chk("late slotValid", slotValid, 8'h01);
        chk("late slotIdx", slotIdx, 48'd2);
        chk("late ramIndex", ramIndex, 6'd0);
        tick();
        chk("late pulse end", evalLate, 1'b0);
        chk("late ramIndex step", ramIndex, 6'd1);
        wait_done(n);
        chk("late rescan latency", n, 65);
        start_line(10'd0);
        chk("rescan slotValid", slotValid, 8'h03);
        chk("rescan slotIdx", slotIdx, {36'd0, 6'd40, 6'd2});
        wait_done(n);

        // Asynchronous reset mid-scan
        start_line(10'd103);
        wait_done(n);
        start_line(10'd103);
        repeat (29) tick();
        chk("pre-reset slotValid", slotValid, 8'h03);
        rst = 1'b1;
        #1;
        chk("mid-scan reset outputs", {slotIdx, slotValid, lineOverflow, busy, evalDone, evalLate, ramIndex}, '0);
        tick();
        rst = 1'b0;
        tick();
        start_line(10'd103);
        chk("post-reset slotValid", slotValid, 8'h00);
        chk("post-reset slotIdx", slotIdx, 48'd0);
        wait_done(n);
        chk("post-reset latency", n, 66);
        start_line(10'd0);
        chk("post-reset rescan slotValid", slotValid, 8'h03);
        wait_done(n);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
